// File: rtl/perceptron_pkg.sv
// Shared types and constants for the perceptron trainer and its classifier.
package perceptron_pkg;
   localparam int N_INPUTS_DEF = 16;
   localparam int W_WIDTH_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Saturation bounds for weights and bias, also used by the classifier.
   localparam logic signed [W_WIDTH_DEF-1:0] W_MAX = {1'b0, {(W_WIDTH_DEF-1){1'b1}}};
   localparam logic signed [W_WIDTH_DEF-1:0] W_MIN = {1'b1, {(W_WIDTH_DEF-1){1'b0}}};
endpackage

// File: rtl/perceptron_trainer_if.sv
// Sample stream into the trainer: valid/ready handshake with feature vector and label.
interface perceptron_trainer_if
   import perceptron_pkg::*;
#(
   parameter int N_INPUTS = N_INPUTS_DEF
);
   logic                s_valid;
   logic                s_ready;
   logic [N_INPUTS-1:0] s_x;
   logic                s_label;

   modport master (output s_valid, output s_x, output s_label, input s_ready);
   modport slave  (input s_valid, input s_x, input s_label, output s_ready);
endinterface

// File: rtl/perceptron_trainer_sat_addsub.sv
// Combinational saturating +/-LR step on one signed weight, pass-through when disabled.
module sat_addsub
   import perceptron_pkg::*;
#(
   parameter int W_WIDTH = W_WIDTH_DEF,
   parameter int LR      = 1
)(
   input  logic               en,
   input  logic               sub,
   input  logic [W_WIDTH-1:0] a,
   output logic [W_WIDTH-1:0] y
);
   localparam logic [W_WIDTH:0] STEP = (W_WIDTH+1)'(LR);

   logic [W_WIDTH:0] ext;
   logic [W_WIDTH:0] sum;

   always_comb begin
      ext = {a[W_WIDTH-1], a};
      sum = sub ? (ext - STEP) : (ext + STEP);
      y   = a;
      if (en) begin
         // Top two bits disagree only on overflow; the sign bit picks the rail.
         if (sum[W_WIDTH] != sum[W_WIDTH-1])
            y = {sum[W_WIDTH], {(W_WIDTH-1){~sum[W_WIDTH]}}};
         else
            y = sum[W_WIDTH-1:0];
      end
   end
endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron training stage: latches a sample, waits for the classifier's
// prediction, applies the perceptron rule to the weight bank and counts errors.
//
// state  | meaning
// IDLE   | ready for a sample
// WAIT   | sample forwarded, waiting for pred_valid (bounded by TIMEOUT)
// UPDATE | compare prediction to label, adjust weights/bias on error
// DONE   | one-cycle completion pulse
module perceptron_trainer
   import perceptron_pkg::*;
#(
   parameter int N_INPUTS = N_INPUTS_DEF,
   parameter int W_WIDTH  = W_WIDTH_DEF,
   parameter int LR       = 1,
   parameter int TIMEOUT  = 15
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        train_en,
   perceptron_trainer_if.slave         s,
   output logic [N_INPUTS-1:0]         x_out,
   input  logic                        pred_valid,
   input  logic                        pred_class,
   output logic [N_INPUTS*W_WIDTH-1:0] weights,
   output logic [W_WIDTH-1:0]          bias,
   output logic                        upd_done,
   output logic                        err_flag,
   output logic                        timeout_flag,
   output logic [7:0]                  err_count,
   input  logic                        clr_count
);
   localparam int            TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);

   state_t                        state, state_nx;
   logic [TW-1:0]                 timer;
   logic                          label_q;
   logic                          pred_q;
   logic                          err;
   logic [N_INPUTS*W_WIDTH-1:0]   weights_nx;
   logic [W_WIDTH-1:0]            bias_nx;

   assign err = (pred_q != label_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      s.s_ready = 1'b0;
      upd_done  = 1'b0;
      case (state)
         IDLE: begin
            s.s_ready = 1'b1;
            if (s.s_valid) state_nx = WAIT;
         end
         WAIT: begin
            if (pred_valid)      state_nx = UPDATE;
            else if (timer == '0) state_nx = DONE;
         end
         UPDATE: state_nx = DONE;
         DONE: begin
            upd_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Positive error pushes active weights up, negative error pushes them down.
   for (genvar i = 0; i < N_INPUTS; i++) begin : g_w
      sat_addsub #(.W_WIDTH(W_WIDTH), .LR(LR)) u_w (
         .en  (x_out[i]),
         .sub (~label_q),
         .a   (weights[i*W_WIDTH +: W_WIDTH]),
         .y   (weights_nx[i*W_WIDTH +: W_WIDTH])
      );
   end

   sat_addsub #(.W_WIDTH(W_WIDTH), .LR(LR)) u_bias (
      .en  (1'b1),
      .sub (~label_q),
      .a   (bias),
      .y   (bias_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_out        <= '0;
         label_q      <= 1'b0;
         pred_q       <= 1'b0;
         timer        <= '0;
         weights      <= '0;
         bias         <= '0;
         err_flag     <= 1'b0;
         timeout_flag <= 1'b0;
         err_count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s.s_valid) begin
                  x_out   <= s.s_x;
                  label_q <= s.s_label;
                  timer   <= T_LOAD;
               end
            end
            WAIT: begin
               if (pred_valid)       pred_q       <= pred_class;
               else if (timer == '0) timeout_flag <= 1'b1;
               else                  timer        <= timer - TW'(1);
            end
            UPDATE: begin
               err_flag     <= err;
               timeout_flag <= 1'b0;
               if (err && train_en) begin
                  weights <= weights_nx;
                  bias    <= bias_nx;
               end
            end
            default: ;
         endcase

         if (clr_count)
            err_count <= '0;
         else if (state == UPDATE && err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end
endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with hand-computed expected values.
module tb_perceptron_trainer;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         train_en = 1'b0;
   logic         pred_valid = 1'b0;
   logic         pred_class = 1'b0;
   logic         clr_count = 1'b0;
   logic [15:0]  x_out;
   logic [127:0] weights;
   logic [7:0]   bias;
   logic [7:0]   err_count;
   logic         upd_done, err_flag, timeout_flag;
   int           n_chk = 0;
   int           n_bad = 0;

   perceptron_trainer_if #(.N_INPUTS(16)) s_if ();

   perceptron_trainer #(.N_INPUTS(16), .W_WIDTH(8), .LR(1), .TIMEOUT(15)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .train_en     (train_en),
      .s            (s_if),
      .x_out        (x_out),
      .pred_valid   (pred_valid),
      .pred_class   (pred_class),
      .weights      (weights),
      .bias         (bias),
      .upd_done     (upd_done),
      .err_flag     (err_flag),
      .timeout_flag (timeout_flag),
      .err_count    (err_count),
      .clr_count    (clr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one sample from IDLE and returns in DONE; pred arrives after dly WAIT cycles.
   task automatic run_sample(input logic [15:0] x, input logic lbl, input logic pc,
                             input int dly, input logic clr);
      tick;
      chk("s_ready_idle", s_if.s_ready, 1);
      s_if.s_valid = 1'b1;
      s_if.s_x     = x;
      s_if.s_label = lbl;
      tick;
      s_if.s_valid = 1'b0;
      s_if.s_x     = ~x;
      s_if.s_label = ~lbl;
      chk("s_ready_wait", s_if.s_ready, 0);
      chk("x_out", x_out, x);
      repeat (dly) tick;
      pred_valid = 1'b1;
      pred_class = pc;
      tick;
      pred_valid = 1'b0;
      clr_count  = clr;
      chk("upd_done_early", upd_done, 0);
      tick;
      clr_count = 1'b0;
      chk("upd_done", upd_done, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      s_if.s_valid = 1'b0;
      s_if.s_x     = '0;
      s_if.s_label = 1'b0;

      #2;
      chk("rst_s_ready", s_if.s_ready, 1);
      chk("rst_weights", weights, 0);
      chk("rst_bias", bias, 0);
      chk("rst_x_out", x_out, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_flags", {upd_done, err_flag, timeout_flag}, 0);
      #10 rst_n = 1'b1;
      train_en = 1'b1;

      // Positive error on features 0 and 2.
      run_sample(16'h0005, 1'b1, 1'b0, 0, 1'b0);
      chk("pos_weights", weights, 128'h010001);
      chk("pos_bias", bias, 8'h01);
      chk("pos_err_flag", err_flag, 1);
      chk("pos_err_count", err_count, 1);
      chk("pos_timeout_flag", timeout_flag, 0);

      // Correct prediction leaves the model alone.
      run_sample(16'hFFFF, 1'b0, 1'b0, 2, 1'b0);
      chk("ok_weights", weights, 128'h010001);
      chk("ok_bias", bias, 8'h01);
      chk("ok_err_flag", err_flag, 0);
      chk("ok_err_count", err_count, 1);

      // Asynchronous reset in the middle of WAIT.
      tick;
      s_if.s_valid = 1'b1;
      s_if.s_x     = 16'h1234;
      s_if.s_label = 1'b1;
      tick;
      s_if.s_valid = 1'b0;
      chk("mid_wait_s_ready", s_if.s_ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_weights", weights, 0);
      chk("arst_bias", bias, 0);
      chk("arst_x_out", x_out, 0);
      chk("arst_err_count", err_count, 0);
      chk("arst_flags", {upd_done, err_flag, timeout_flag}, 0);
      chk("arst_s_ready", s_if.s_ready, 1);
      #3 rst_n = 1'b1;
      tick;
      chk("post_rst_s_ready", s_if.s_ready, 1);

      // Negative errors drive w15 and bias to the lower rail.
      for (int i = 0; i < 130; i++) run_sample(16'h8000, 1'b0, 1'b1, 0, 1'b0);
      chk("sat_weights", weights, {8'h80, 120'h0});
      chk("sat_bias", bias, 8'h80);
      chk("sat_err_count_130", err_count, 130);
      for (int i = 0; i < 170; i++) run_sample(16'h8000, 1'b0, 1'b1, 0, 1'b0);
      chk("sat_err_count_255", err_count, 255);
      run_sample(16'h8000, 1'b0, 1'b1, 0, 1'b1);
      chk("clr_priority", err_count, 0);
      chk("clr_weights", weights, {8'h80, 120'h0});

      // Stray pred_valid in IDLE, then a timeout.
      tick;
      pred_valid = 1'b1;
      pred_class = 1'b0;
      tick;
      pred_valid = 1'b0;
      chk("stray_pred_s_ready", s_if.s_ready, 1);
      s_if.s_valid = 1'b1;
      s_if.s_x     = 16'hFFFF;
      s_if.s_label = 1'b1;
      tick;
      s_if.s_valid = 1'b0;
      n = 1;
      while (!upd_done && n < 40) begin
         tick;
         n++;
      end
      chk("timeout_upd_done", upd_done, 1);
      chk("timeout_wait_cycles", n - 1, 15);
      chk("timeout_flag", timeout_flag, 1);
      chk("timeout_weights", weights, {8'h80, 120'h0});
      chk("timeout_bias", bias, 8'h80);
      chk("timeout_err_count", err_count, 0);

      // Inference only: error counted, model frozen.
      train_en = 1'b0;
      run_sample(16'h00FF, 1'b1, 1'b0, 1, 1'b0);
      chk("inf_weights", weights, {8'h80, 120'h0});
      chk("inf_bias", bias, 8'h80);
      chk("inf_err_flag", err_flag, 1);
      chk("inf_err_count", err_count, 1);
      chk("inf_timeout_flag", timeout_flag, 0);

      // Positive error climbs back off the rail.
      train_en = 1'b1;
      run_sample(16'h8001, 1'b1, 1'b0, 3, 1'b0);
      chk("recover_weights", weights, {8'h81, 112'h0, 8'h01});
      chk("recover_bias", bias, 8'h81);
      chk("recover_err_count", err_count, 2);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Online training stage placed beside the perceptron classifier. It accepts labelled binary samples and forwards the feature vector to the classifier. It then waits for the classifier's prediction and applies the perceptron learning rule to a signed weight bank and bias. The weight bank and bias are driven back into the classifier. The block also keeps a saturating misclassification counter for host readout.

## Interface
Parameters:
- N_INPUTS, 16, number of binary features; matches the classifier's 16 input bits (ui_in plus uio_in).
- W_WIDTH, 8, width of each signed two's-complement weight and of the bias.
- LR, 1, learning-rate step added or subtracted per update; must be 1..2^(W_WIDTH-1)-1.
- TIMEOUT, 15, maximum cycles spent in WAIT before aborting.

Ports (clock and reset first):
- clk, in, 1, single clock; all state on the rising edge.
- rst_n, in, 1, reset, asynchronous and active-low.
- train_en, in, 1, 1 = update weights on error; 0 = inference only, weights frozen.
- s_valid, in, 1, sample offered.
- s_ready, out, 1, trainer can accept a sample.
- s_x, in, N_INPUTS, binary feature vector.
- s_label, in, 1, target class.
- x_out, out, N_INPUTS, registered feature vector to the classifier.
- pred_valid, in, 1, classifier prediction strobe.
- pred_class, in, 1, classifier output.
- weights, out, N_INPUTS*W_WIDTH, weight i occupies bits [i*W_WIDTH +: W_WIDTH].
- bias, out, W_WIDTH, signed bias.
- upd_done, out, 1, one-cycle pulse when a sample is fully processed.
- err_flag, out, 1, registered: last sample was misclassified.
- timeout_flag, out, 1, registered: last sample aborted in WAIT.
- err_count, out, 8, saturating misclassification count.
- clr_count, in, 1, synchronous clear of err_count.

## Operation
The FSM has four states.

IDLE
- s_ready = 1.
- On s_valid: latch s_x into x_out and latch s_label; go to WAIT and clear the timer.

WAIT
- s_ready = 0.
- On pred_valid: latch pred_class and go to UPDATE.
- Otherwise increment the timer. When the timer reaches TIMEOUT, go to DONE and set timeout_flag = 1. Weights are untouched.

UPDATE
- s_ready = 0.
- err = (pred_class != label).
- If err and train_en:
  - label = 1: every weight with x_out[i] = 1 gets +LR, and bias gets +LR.
  - label = 0: every weight with x_out[i] = 1 gets −LR, and bias gets −LR.
  - All weights update in parallel in this one cycle.
- Arithmetic is performed at W_WIDTH+1 bits and then saturated to [−2^(W_WIDTH−1), 2^(W_WIDTH−1)−1]; values never wrap.
- err_flag <= err and timeout_flag <= 0.
- If err, err_count increments, saturating at 255. This happens even when train_en = 0.
- Go to DONE.

DONE
- upd_done = 1 for this cycle only; s_ready = 0.
- Go to IDLE.

Boundary rules:
- clr_count has priority over an increment in the same cycle; the result is 0.
- pred_valid outside WAIT is ignored.
- A change to s_x or s_label while not in IDLE has no effect.
- train_en is sampled in UPDATE only.
- Asserting rst_n low at any point, including mid-UPDATE, returns the block to IDLE immediately. No partial weight update survives.

## Timing
Reset values:
- state IDLE, s_ready 1, x_out 0, weights 0, bias 0.
- upd_done 0, err_flag 0, timeout_flag 0, err_count 0.

Latency:
- Sample accept to WAIT: 1 cycle.
- pred_valid seen in WAIT N to UPDATE: cycle N+1; DONE and upd_done at N+2; IDLE (s_ready = 1) at N+3.
- Minimum sample spacing is 4 cycles when pred_valid arrives on the first WAIT cycle.

Other timing rules:
- Weights change only on the UPDATE→DONE edge and are stable at all other times.
- A timeout produces IDLE → WAIT × TIMEOUT → DONE → IDLE.
- All outputs are registered except s_ready and upd_done, which are decoded from state.

## Structure
- perceptron_pkg holds:
  - N_INPUTS and W_WIDTH defaults;
  - the state enum (IDLE, WAIT, UPDATE, DONE);
  - the saturation bounds W_MAX and W_MIN, shared with the classifier.
- Sub-module sat_addsub (W_WIDTH, LR) is natural: combinational saturating ±LR with an enable. It is instantiated N_INPUTS+1 times, once per weight and once for the bias.

## Test plan
1. Reset: pulse rst_n low mid-WAIT. All outputs must return to the reset values asynchronously, and s_ready must be 1 after release.
2. Positive error:
   - Stimulus: s_x = 16'h0005, label 1, pred_class 0, train_en 1.
   - Required: w0 = w2 = +1, bias = +1, all other weights 0; err_flag 1; err_count 1; upd_done exactly 2 cycles after pred_valid.
3. Correct prediction:
   - Stimulus: s_x = 16'hFFFF, label 0, pred_class 0.
   - Required: weights unchanged, err_flag 0, err_count unchanged.
4. Saturation:
   - Stimulus: 130 negative-error samples with s_x = 16'h8000.
   - Required: w15 = −128 and bias = −128 with no wrap; err_count = 130.
   - Continue to 300 errors: err_count holds at 255. Then clr_count together with an error gives err_count 0.
5. Timeout: withhold pred_valid. Required: DONE after exactly 15 WAIT cycles, timeout_flag 1, weights unchanged, err_count unchanged.
6. Inference mode: train_en 0 with a misclassified sample. Required: weights frozen, err_flag 1, err_count increments.
